// File: rtl/lcd_text_engine.sv
// lcd_text_engine: streams a ROWS x COLS character buffer to an HD44780
// over the 8-bit bus; each byte is sent as SETUP, then EN pulse, then HOLD.
module lcd_text_engine #(
  parameter int ROWS           = 2,
  parameter int COLS           = 16,
  parameter int EN_CYCLES      = 16,
  parameter int DLY_CYCLES     = 2000,
  parameter int CLR_DLY_CYCLES = 100000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iWR_EN,
  input  logic [6:0] iWR_ADDR,
  input  logic [7:0] iWR_DATA,
  input  logic       iREFRESH,
  input  logic       iAUTO,
  output logic       oBUSY,
  output logic       oFRAME_DONE,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);
  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {INIT, IDLE, ROWADDR, CHAR} state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t      state_q;
  phase_t      ph_q;
  logic [1:0]  idx_q;
  logic [1:0]  row_q;
  logic [4:0]  col_q;
  logic [31:0] cnt_q;
  logic [7:0]  data_q;
  logic        rs_q;
  logic        en_q;
  logic        fd_q;
  logic        busy_q;
  logic        pend_q;
  logic [7:0]  mem_q [N];

  state_t      t_state;
  logic [1:0]  t_idx;
  logic [1:0]  t_row;
  logic [4:0]  t_col;
  logic        t_idle;
  logic [AW-1:0] t_a;
  logic [7:0]  t_data;
  logic        t_rs;
  logic        last;
  logic        go;
  logic [31:0] hold_len;

  assign go   = iAUTO | pend_q | iREFRESH;
  assign last = (state_q == CHAR) &&
                (row_q == 2'(ROWS - 1)) &&
                (col_q == 5'(COLS - 1));
  assign hold_len = (!rs_q && data_q == 8'h01) ?
                    32'(CLR_DLY_CYCLES) : 32'(DLY_CYCLES);

  // Position of the byte to send next (current one when in PH_LOAD)
  always_comb begin
    t_state = state_q;
    t_idx   = idx_q;
    t_row   = row_q;
    t_col   = col_q;
    t_idle  = 1'b0;
    if (state_q == IDLE) begin
      t_state = ROWADDR;
      t_row   = '0;
      t_col   = '0;
    end else if (ph_q != PH_LOAD) begin
      unique case (state_q)
        INIT: begin
          if (idx_q == 2'd3) begin
            t_state = ROWADDR;
            t_row   = '0;
          end else begin
            t_idx = idx_q + 2'd1;
          end
        end
        ROWADDR: begin
          t_state = CHAR;
          t_col   = '0;
        end
        CHAR: begin
          if (col_q != 5'(COLS - 1)) begin
            t_col = col_q + 5'd1;
          end else if (row_q != 2'(ROWS - 1)) begin
            t_state = ROWADDR;
            t_row   = row_q + 2'd1;
          end else if (go) begin
            t_state = ROWADDR;
            t_row   = '0;
          end else begin
            t_state = IDLE;
            t_idle  = 1'b1;
          end
        end
        IDLE: t_idle = 1'b0;
      endcase
    end
  end

  // Bus byte for that position; a same-cycle buffer write is forwarded
  always_comb begin
    t_a    = AW'(32'(t_row) * 32'(COLS) + 32'(t_col));
    t_rs   = 1'b0;
    t_data = 8'h00;
    unique case (t_state)
      INIT: begin
        unique case (t_idx)
          2'd0: t_data = 8'h38;
          2'd1: t_data = 8'h0C;
          2'd2: t_data = 8'h01;
          2'd3: t_data = 8'h06;
        endcase
      end
      ROWADDR: begin
        unique case (t_row)
          2'd0: t_data = 8'h80;
          2'd1: t_data = 8'hC0;
          2'd2: t_data = 8'h94;
          2'd3: t_data = 8'hD4;
        endcase
      end
      CHAR: begin
        t_rs   = 1'b1;
        t_data = (iWR_EN && iWR_ADDR == 7'(t_a)) ?
                 iWR_DATA : mem_q[t_a];
      end
      IDLE: t_data = 8'h00;
    endcase
  end

  // Character buffer, blank on reset, out-of-range writes dropped
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < N; i++) mem_q[i] <= 8'h20;
    end else if (iWR_EN && iWR_ADDR < 7'(N)) begin
      mem_q[iWR_ADDR[AW-1:0]] <= iWR_DATA;
    end
  end

  // Frame sequencer and byte timing, all outputs registered
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= INIT;
      ph_q    <= PH_LOAD;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (iREFRESH && state_q != IDLE) pend_q <= 1'b1;
      if (state_q == IDLE) begin
        if (iREFRESH) begin
          state_q <= t_state;
          row_q   <= t_row;
          col_q   <= t_col;
          data_q  <= t_data;
          rs_q    <= t_rs;
          ph_q    <= PH_SETUP;
          busy_q  <= 1'b1;
        end
      end else begin
        unique case (ph_q)
          PH_LOAD: begin
            data_q <= t_data;
            rs_q   <= t_rs;
            ph_q   <= PH_SETUP;
          end
          PH_SETUP: begin
            en_q  <= 1'b1;
            cnt_q <= 32'(EN_CYCLES);
            ph_q  <= PH_PULSE;
          end
          PH_PULSE: begin
            if (cnt_q == 32'd1) begin
              en_q  <= 1'b0;
              cnt_q <= hold_len;
              ph_q  <= PH_HOLD;
              fd_q  <= last && (hold_len == 32'd1);
            end else begin
              cnt_q <= cnt_q - 32'd1;
            end
          end
          PH_HOLD: begin
            if (cnt_q != 32'd1) begin
              cnt_q <= cnt_q - 32'd1;
              fd_q  <= last && (cnt_q == 32'd2);
            end else begin
              state_q <= t_state;
              idx_q   <= t_idx;
              row_q   <= t_row;
              col_q   <= t_col;
              if (last) pend_q <= 1'b0;
              if (t_idle) begin
                busy_q <= 1'b0;
              end else begin
                data_q <= t_data;
                rs_q   <= t_rs;
                ph_q   <= PH_SETUP;
              end
            end
          end
        endcase
      end
    end
  end

  assign oBUSY       = busy_q;
  assign oFRAME_DONE = fd_q;
  assign LCD_DATA    = data_q;
  assign LCD_RS      = rs_q;
  assign LCD_RW      = 1'b0;
  assign LCD_EN      = en_q;

endmodule

// File: tb/tb_lcd_text_engine.sv
// tb_lcd_text_engine: bus monitor plus frame-level reference model
// for lcd_text_engine with short timing parameters.
module tb_lcd_text_engine;
  localparam int ROWS = 2;
  localparam int COLS = 16;
  localparam int ENC  = 4;
  localparam int DLY  = 8;
  localparam int CLR  = 32;
  localparam int N    = ROWS * COLS;

  logic       clk = 1'b0;
  logic       iRST = 1'b1;
  logic       iWR_EN = 1'b0;
  logic [6:0] iWR_ADDR = '0;
  logic [7:0] iWR_DATA = '0;
  logic       iREFRESH = 1'b0;
  logic       iAUTO = 1'b0;
  logic       oBUSY;
  logic       oFRAME_DONE;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  always #5 clk = ~clk;

  lcd_text_engine #(
    .ROWS(ROWS), .COLS(COLS), .EN_CYCLES(ENC),
    .DLY_CYCLES(DLY), .CLR_DLY_CYCLES(CLR)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iWR_EN(iWR_EN),
    .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA),
    .iREFRESH(iREFRESH), .iAUTO(iAUTO),
    .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  typedef struct {
    logic [6:0] addr;
    logic [7:0] data;
    int         pos;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_fd = 0;
  logic [7:0] model [N];
  logic [8:0] got [$];
  logic [8:0] exp_q [$];
  logic [8:0] prev_q [$];
  vec_t       tbl [6];

  logic       en_p = 1'b0;
  int         wcnt = 0;
  int         lrun = 0;
  bit         gap_ok = 1'b0;
  bit         stab = 1'b1;
  logic [8:0] cur = '0;
  logic [8:0] last_b = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  function automatic int hold_of(input logic [8:0] b);
    return (b == 9'h001) ? CLR : DLY;
  endfunction

  function automatic logic [7:0] base(input int r);
    case (r)
      0: return 8'h00;
      1: return 8'h40;
      2: return 8'h14;
      default: return 8'h54;
    endcase
  endfunction

  // Bus monitor: captures each byte at EN rise, checks width and gaps
  always @(negedge clk) begin
    if (iRST) begin
      en_p = 1'b0;
      wcnt = 0;
      lrun = 0;
      gap_ok = 1'b0;
    end else begin
      if (oFRAME_DONE) n_fd++;
      if (!oBUSY) gap_ok = 1'b0;
      if (LCD_EN && !en_p) begin
        if (gap_ok) chk("hold_gap", lrun - 1, hold_of(last_b));
        cur = {LCD_RS, LCD_DATA};
        got.push_back(cur);
        wcnt = 1;
        stab = 1'b1;
      end else if (LCD_EN) begin
        wcnt++;
        if ({LCD_RS, LCD_DATA} !== cur) stab = 1'b0;
      end else if (en_p) begin
        chk("pulse_width", wcnt, ENC);
        chk("pulse_stable", 32'(stab), 1);
        last_b = cur;
        lrun = 1;
        gap_ok = 1'b1;
      end else begin
        lrun++;
      end
      en_p = LCD_EN;
    end
  end

  task automatic push_frame(input bit with_init);
    if (with_init) begin
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h006);
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({1'b0, 8'h80 | base(r)});
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({1'b1, model[r * COLS + c]});
    end
  endtask

  task automatic cmp_frames(input string nm);
    chk({nm, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(nm, got[i], exp_q[i]);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    iWR_EN = 1'b1;
    iWR_ADDR = a;
    iWR_DATA = d;
    @(negedge clk);
    iWR_EN = 1'b0;
    if (int'(a) < N) model[int'(a)] = d;
  endtask

  task automatic refresh();
    iREFRESH = 1'b1;
    @(negedge clk);
    iREFRESH = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (oBUSY && k < 3000);
    chk({nm, "_idle"}, 32'(oBUSY), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_caps();
    got.delete();
    exp_q.delete();
    n_fd = 0;
  endtask

  initial begin
    tbl[0] = '{7'd5,   8'h61, 6};
    tbl[1] = '{7'd16,  8'h62, 18};
    tbl[2] = '{7'd15,  8'h63, 16};
    tbl[3] = '{7'd32,  8'h64, -1};
    tbl[4] = '{7'd100, 8'h65, -1};
    tbl[5] = '{7'd27,  8'h66, 29};
    for (int i = 0; i < N; i++) model[i] = 8'h20;

    // Reset values and the power-up frame
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(LCD_EN), 0);
    chk("rst_data", 32'(LCD_DATA), 0);
    chk("rst_rs", 32'(LCD_RS), 0);
    chk("rst_busy", 32'(oBUSY), 1);
    chk("rst_fd", 32'(oFRAME_DONE), 0);
    chk("rw_low", 32'(LCD_RW), 0);
    clear_caps();
    iRST = 1'b0;
    @(negedge clk);
    chk("init_setup", {LCD_EN, LCD_RS, LCD_DATA}, 10'h038);
    wait_idle("init");
    push_frame(1'b1);
    cmp_frames("init_frame");
    chk("init_fd", n_fd, 1);
    repeat (20) @(negedge clk);
    chk("idle_quiet", got.size(), 38);

    // Refresh from IDLE with two edge characters
    wr(7'd0, 8'h41);
    wr(7'd31, 8'h5A);
    clear_caps();
    refresh();
    chk("refresh_setup", {oBUSY, LCD_EN, LCD_RS, LCD_DATA}, 11'h480);
    wait_idle("refresh");
    push_frame(1'b0);
    cmp_frames("refresh_frame");
    chk("refresh_fd", n_fd, 1);

    // Table of writes, including out-of-range addresses
    for (int i = 0; i < 6; i++) wr(tbl[i].addr, tbl[i].data);
    clear_caps();
    refresh();
    wait_idle("table");
    push_frame(1'b0);
    cmp_frames("table_frame");
    for (int i = 0; i < 6; i++)
      if (tbl[i].pos >= 0 && tbl[i].pos < got.size())
        chk("table_pos", got[tbl[i].pos], {1'b1, tbl[i].data});

    // Address 32 is outside the buffer: frame must repeat exactly
    prev_q = got;
    wr(7'd32, 8'h77);
    clear_caps();
    refresh();
    wait_idle("addr32");
    exp_q = prev_q;
    cmp_frames("addr32_frame");

    // Random writes checked against the buffer model
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 6; w++)
        wr(7'($urandom_range(0, 40)), 8'($urandom_range(33, 126)));
      clear_caps();
      refresh();
      wait_idle("rand");
      push_frame(1'b0);
      cmp_frames("rand_frame");
    end

    // Refresh requests during a frame merge into one extra frame
    clear_caps();
    refresh();
    repeat (20) @(negedge clk);
    refresh();
    repeat (80) @(negedge clk);
    refresh();
    repeat (100) @(negedge clk);
    refresh();
    wait_idle("pend");
    push_frame(1'b0);
    push_frame(1'b0);
    cmp_frames("pend_frames");
    chk("pend_fd", n_fd, 2);

    // Auto mode with a write landing mid row 0
    begin
      int k;
      iAUTO = 1'b1;
      clear_caps();
      refresh();
      k = 0;
      while (got.size() < 5 && k < 500) begin
        @(negedge clk);
        k++;
      end
      chk("auto_row0", 32'(got.size() >= 5), 1);
      wr(7'd20, 8'h31);
      k = 0;
      while (!oFRAME_DONE && k < 1000) begin
        @(negedge clk);
        k++;
      end
      chk("auto_fd_seen", 32'(oFRAME_DONE), 1);
      @(negedge clk);
      chk("auto_next_80", {oBUSY, LCD_EN, LCD_RS, LCD_DATA}, 11'h480);
      iAUTO = 1'b0;
      wait_idle("auto");
      push_frame(1'b0);
      push_frame(1'b0);
      cmp_frames("auto_frames");
      if (got.size() > 22) chk("auto_r1c4", got[22], 9'h131);
      chk("auto_fd", n_fd, 2);
    end

    // Reset while EN is high, then the init sequence again
    begin
      int k;
      clear_caps();
      refresh();
      k = 0;
      while (!(LCD_EN && got.size() >= 3) && k < 500) begin
        @(negedge clk);
        k++;
      end
      chk("mid_pulse_seen", 32'(LCD_EN), 1);
      iRST = 1'b1;
      @(negedge clk);
      chk("rst_en_drop", 32'(LCD_EN), 0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++) model[i] = 8'h20;
      clear_caps();
      iRST = 1'b0;
      @(negedge clk);
      chk("reinit_setup", {LCD_EN, LCD_RS, LCD_DATA}, 10'h038);
      wait_idle("reinit");
      push_frame(1'b1);
      cmp_frames("reinit_frame");
      chk("reinit_fd", n_fd, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
